n2_com_dp_32x84_fifo_ctl: RTL
=============================

// Module: n2_com_dp_32x84_fifo_ctl
// PURPOSE
//  Single-clock FIFO sequencer for one 32-entry x 84-bit two-port register-file array.
//  Converts a valid/ready push/pop stream into the array's wr_adr/wr_en/rd_adr/rd_en controls.
//  Hides the array's 1-cycle read latency with a 2-entry output buffer, sustaining 1 pop/cycle.
//  Honours the test-controller write inhibit; drives the array read/write power-enables.
// PARAMETERS
//  DEPTH  32  array entries (power of 2)
//  AW     5   array address width, log2(DEPTH)
//  DW     84  data width
// PORTS
//  l2clk                 in   1     sole clock; array rdclk/wrclk tie to it
//  rst                   in   1     asynchronous reset, active-high
//  flush                 in   1     synchronous clear of all FIFO state
//  tcu_array_wr_inhibit  in   1     1 = block all array writes
//  push_vld              in   1     producer data valid
//  push_data             in   DW    producer data
//  push_rdy              out  1     space available and writes allowed
//  pop_vld               out  1     pop_data valid
//  pop_data              out  DW    head of FIFO
//  pop_rdy               in   1     consumer accepts
//  wr_adr                out  AW    array write address
//  wr_en                 out  1     array write enable
//  wr_pce                out  1     array write power/clock enable (= wr_en)
//  din                   out  DW    array write data (= push_data)
//  rd_adr                out  AW    array read address
//  rd_en                 out  1     array read enable
//  rd_pce                out  1     array read power/clock enable (= rd_en)
//  dout                  in   DW    array read data, valid the cycle after rd_en
//  level                 out  AW+2  total occupancy: array + in-flight + output buffer (0..34)
// BEHAVIOUR
//  Reset (async) and flush clear wptr, rptr, arr_cnt, rd_inflight and ob_cnt.
//  - push_rdy, pop_vld, wr_en, rd_en and level all read 0.
//  - Outputs are combinational from that state, so they read 0 in the cycle flush is high.
//  - A push or pop offered during flush is ignored; read data in flight is discarded.
//  Push and write:
//  - push_fire = push_vld & push_rdy.
//  - push_rdy = !flush & !tcu_array_wr_inhibit & (arr_cnt != DEPTH).
//  - wr_en = push_fire, combinational. wr_adr = wptr[AW-1:0].
//  - wptr is AW+1 bits; it increments on push_fire and wraps 31 -> 0 with the wrap bit toggling.
//  Read issue:
//  - rd_en = !flush & (arr_cnt != 0) & (ob_cnt + rd_inflight - pop_fire < 2).
//  - rd_adr = rptr; rptr increments on rd_en. rd_inflight <= rd_en.
//  - arr_cnt counts only entries already written, so a read never targets this cycle's write address.
//  - Simultaneous push and read: arr_cnt unchanged.
//  Output buffer:
//  - 2-entry in-order buffer, ob0 = head.
//  - At the clock edge after rd_inflight, dout is written into the first free slot, after the current pop has been applied.
//  - pop_vld = (ob_cnt != 0). pop_data = ob0. pop_fire = pop_vld & pop_rdy.
//  - When pop_fire is high, ob1 shifts into ob0.
//  - Invariant ob_cnt + rd_inflight <= 2, so the buffer never overflows.
//  Latency without bypass:
//  - Push accepted in cycle 0 -> rd_en in cycle 1 -> dout valid in cycle 2 -> pop_vld in cycle 3.
//  - Steady state: 1 push and 1 pop per cycle.
//  Full and empty:
//  - arr_cnt == 32 -> push_rdy = 0.
//  - arr_cnt == 0 -> no reads.
//  - Pointer compare uses the wrap bit: full when addresses are equal and wrap bits differ.
//  Inhibit:
//  - tcu_array_wr_inhibit forces push_rdy = 0. Reads and pops continue, so the FIFO drains.
//  Data-path width:
//  - level = arr_cnt + rd_inflight + ob_cnt, unsigned, never saturates. Maximum 34.
// CONFIGURATION
//  FIFO_CTL_BYPASS_EN defined: empty-path bypass.
//  - Condition: arr_cnt == 0, rd_inflight == 0 and ob_cnt - pop_fire < 2.
//  - Effect: push_data goes straight into the output buffer; wr_en stays 0 and wptr is unchanged.
//  - Result: push in cycle 0 -> pop_vld in cycle 1.
//  - Ordering is preserved because the bypass is taken only when nothing is queued behind.
//  FIFO_CTL_BYPASS_EN undefined:
//  - Every push writes the array; 3-cycle latency as described above.
// STRUCTURE
//  Package n2_com_dp_fifo_ctl_pkg holds:
//  - localparams DEPTH/AW/DW and OB_DEPTH = 2;
//  - typedef ptr_t = logic [AW:0];
//  - typedef data_t = logic [DW-1:0].
//  Sub-module n2_com_dp_fifo_obuf is the 2-entry output buffer (push, pop, cnt).
//  The top level holds the pointers, arr_cnt, rd_inflight and the issue logic.
//  The bench instantiates the real array model; this block does not drive its scan or tcu clocks.
// TESTING
//  1. Reset, then single push 0xA5 in cycle 0, pop_rdy = 1 -> pop_vld and pop_data = 0xA5 in cycle 3 (cycle 1 with bypass); level returns to 0.
//  2. Fill: 32 back-to-back pushes with pop_rdy = 0 -> after the first reads, arr_cnt stops at 30, ob_cnt = 2 and level = 32. Push 2 more to reach level = 34; push_rdy then = 0 and the next push is ignored.
//  3. Stream: 100 pushes and pops, pop_rdy = 1, counter data -> 1 pop/cycle after the initial latency, in order, no loss; wptr and rptr wrap 3 times.
//  4. Backpressure: pop_rdy toggles 1010 while streaming -> no overflow of the output buffer, ordering intact, level correct each cycle.
//  5. Flush mid-stream with a read in flight -> all state cleared next cycle; discarded data never appears. Next push 0x3C pops first.
//  6. tcu_array_wr_inhibit = 1 with 5 entries queued -> push_rdy = 0, wr_en never rises, all 5 entries pop out. Deassert -> pushes resume.
//  7. Async rst during a pop and an in-flight read -> outputs clear immediately. First push after release behaves as in test 1.

Source files
------------

// File: rtl/n2_com_dp_fifo_ctl_pkg.sv
// Shared sizes and types for the 32x84 register-file FIFO sequencer.
package n2_com_dp_fifo_ctl_pkg;

  localparam int DEPTH    = 32;
  localparam int AW       = 5;
  localparam int DW       = 84;
  localparam int OB_DEPTH = 2;

  typedef logic [AW:0]   ptr_t;
  typedef logic [DW-1:0] data_t;

endpackage

// File: rtl/n2_com_dp_fifo_obuf.sv
// Two-entry in-order output buffer; ob0 is the head. A pop is applied before
// the incoming entry is placed, so push lands in the first slot free after the pop.
module n2_com_dp_fifo_obuf
  import n2_com_dp_fifo_ctl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [1:0]    cnt,
  output logic [DW-1:0] head
);

  logic [DW-1:0] ob0, ob1;
  logic [DW-1:0] ob0_nxt, ob1_nxt;
  logic [1:0]    cnt_ap, cnt_nxt;

  always_comb begin
    cnt_ap  = cnt - {1'b0, pop};
    ob0_nxt = pop ? ob1 : ob0;
    ob1_nxt = ob1;
    if (push) begin
      if (cnt_ap == 2'd0) ob0_nxt = push_data;
      else                ob1_nxt = push_data;
    end
    cnt_nxt = cnt_ap + {1'b0, push};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 2'd0;
      ob0 <= '0;
      ob1 <= '0;
    end else if (clr) begin
      cnt <= 2'd0;
    end else begin
      cnt <= cnt_nxt;
      ob0 <= ob0_nxt;
      ob1 <= ob1_nxt;
    end
  end

  assign head = ob0;

endmodule

// File: rtl/n2_com_dp_32x84_fifo_ctl.sv
// FIFO sequencer for a 32x84 two-port register file with 1-cycle read latency.
// Optional empty-path bypass (push straight into the output buffer): FIFO_CTL_BYPASS_EN.
module n2_com_dp_32x84_fifo_ctl
  import n2_com_dp_fifo_ctl_pkg::*;
(
  input  logic          l2clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          tcu_array_wr_inhibit,
  input  logic          push_vld,
  input  logic [DW-1:0] push_data,
  output logic          push_rdy,
  output logic          pop_vld,
  output logic [DW-1:0] pop_data,
  input  logic          pop_rdy,
  output logic [AW-1:0] wr_adr,
  output logic          wr_en,
  output logic          wr_pce,
  output logic [DW-1:0] din,
  output logic [AW-1:0] rd_adr,
  output logic          rd_en,
  output logic          rd_pce,
  input  logic [DW-1:0] dout,
  output logic [AW+1:0] level
);

  localparam logic [2:0] OB_LIM = 3'(OB_DEPTH);

  ptr_t          wptr, rptr, arr_cnt;
  logic          rd_inflight;
  logic [1:0]    ob_cnt;
  logic          arr_full, arr_empty;
  logic          push_fire, pop_fire, byp, ob_push;
  logic [2:0]    ob_pend;
  logic [DW-1:0] ob_din;
  logic [AW+1:0] lvl_sum;

  // arr_cnt covers only entries already written; issued reads leave it at once.
  assign arr_cnt   = wptr - rptr;
  assign arr_full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign arr_empty = (wptr == rptr);

  assign push_rdy  = !flush && !tcu_array_wr_inhibit && !arr_full;
  assign push_fire = push_vld && push_rdy;
  assign pop_vld   = !flush && (ob_cnt != 2'd0);
  assign pop_fire  = pop_vld && pop_rdy;

  // Slots the buffer will owe after this cycle's pop; a read may issue only if one stays free.
  assign ob_pend = {1'b0, ob_cnt} + {2'b0, rd_inflight} - {2'b0, pop_fire};
  assign rd_en   = !flush && !arr_empty && (ob_pend < OB_LIM);

`ifdef FIFO_CTL_BYPASS_EN
  assign byp = push_fire && arr_empty && !rd_inflight
               && (({1'b0, ob_cnt} - {2'b0, pop_fire}) < OB_LIM);
`else
  assign byp = 1'b0;
`endif

  assign wr_en  = push_fire && !byp;
  assign wr_pce = wr_en;
  assign wr_adr = wptr[AW-1:0];
  assign din    = push_data;
  assign rd_adr = rptr[AW-1:0];
  assign rd_pce = rd_en;

  assign ob_push = (rd_inflight && !flush) || byp;
  assign ob_din  = rd_inflight ? dout : push_data;

  assign lvl_sum = (AW+2)'(arr_cnt) + (AW+2)'(rd_inflight) + (AW+2)'(ob_cnt);
  assign level   = flush ? '0 : lvl_sum;

  always_ff @(posedge l2clk or posedge rst) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      rd_inflight <= 1'b0;
    end else if (flush) begin
      wptr        <= '0;
      rptr        <= '0;
      rd_inflight <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
      rd_inflight <= rd_en;
    end
  end

  n2_com_dp_fifo_obuf u_obuf (
    .clk       (l2clk),
    .rst       (rst),
    .clr       (flush),
    .push      (ob_push),
    .push_data (ob_din),
    .pop       (pop_fire),
    .cnt       (ob_cnt),
    .head      (pop_data)
  );

endmodule
